// File: rtl/codec_init_seq_if.sv
// ---------------------------------------------------------------------------
// codec_init_seq_if
//   Handshake bundle between the WM8731 configuration sequencer and the
//   i2c_write transfer engine.
//
//   Signals:
//     write        sequencer -> i2c_write   request a register write
//     done         i2c_write -> sequencer   current transfer has completed
//     config_reg   sequencer -> i2c_write   register byte {reg_addr[6:0], value[8]}
//     config_data  sequencer -> i2c_write   data byte value[7:0]
//
//   Modports:
//     master  sequencer side (drives write/config_reg/config_data)
//     slave   i2c_write side (drives done)
// ---------------------------------------------------------------------------
interface codec_init_seq_if;
    logic       write;
    logic       done;
    logic [7:0] config_reg;
    logic [7:0] config_data;

    modport master (
        output write,
        output config_reg,
        output config_data,
        input  done
    );

    modport slave (
        input  write,
        input  config_reg,
        input  config_data,
        output done
    );
endinterface

// File: rtl/codec_init_seq.sv
// ---------------------------------------------------------------------------
// codec_init_seq
//   Table-driven configuration sequencer for the WM8731 audio codec. Walks a
//   fixed 8-entry register table and hands each entry to i2c_write through
//   the write/done handshake, leaving a fixed idle gap between writes.
//   Reports completion or error for status LEDs.
//
//   Ports:
//     sys_clk      in   system clock (50 MHz)
//     rst          in   asynchronous reset, active-high
//     start        in   begin/restart the sequence (IDLE, DONE, ERROR only)
//     bus          if   master side of codec_init_seq_if
//                       (write, done, config_reg, config_data)
//     busy         out  high while issuing, releasing or gapping
//     config_done  out  high once all entries have been written
//     error        out  high after a handshake timeout
//     step         out  index of the current or last table entry
// ---------------------------------------------------------------------------
module codec_init_seq #(
    parameter int NUM_REGS       = 8,
    parameter int GAP_CYCLES     = 500_000,
    parameter int TIMEOUT_CYCLES = 5_000_000,
    parameter bit AUTO_START     = 1'b1
) (
    input  logic                   sys_clk,
    input  logic                   rst,
    input  logic                   start,
    codec_init_seq_if.master       bus,
    output logic                   busy,
    output logic                   config_done,
    output logic                   error,
    output logic [3:0]             step
);

    // One counter serves both the gap timer and the handshake timeout, so it
    // is sized for whichever limit is larger.
    localparam int MAX_CYCLES = (GAP_CYCLES > TIMEOUT_CYCLES) ? GAP_CYCLES : TIMEOUT_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]       LAST_STEP    = 4'(NUM_REGS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_RELEASE,
        S_GAP,
        S_DONE,
        S_ERROR
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic [3:0]       step_next;
    logic             first_cycle;

    // Register table. Returns {reg_addr[6:0], value[8:0]}, which is exactly
    // {config_reg, config_data}.
    function automatic logic [15:0] table_entry(input logic [3:0] idx);
        logic [6:0] addr;
        logic [8:0] value;
        case (idx)
            4'd0:    begin addr = 7'd15; value = 9'h000; end  // reset
            4'd1:    begin addr = 7'd6;  value = 9'h000; end  // power down control
            4'd2:    begin addr = 7'd2;  value = 9'h179; end  // headphone volume
            4'd3:    begin addr = 7'd4;  value = 9'h012; end  // analog path
            4'd4:    begin addr = 7'd5;  value = 9'h000; end  // digital path
            4'd5:    begin addr = 7'd7;  value = 9'h00A; end  // digital interface
            4'd6:    begin addr = 7'd8;  value = 9'h000; end  // sampling control
            4'd7:    begin addr = 7'd9;  value = 9'h001; end  // active
            default: begin addr = 7'd15; value = 9'h000; end
        endcase
        return {addr, value};
    endfunction

    // Next-state logic. The shared counter only runs in the timed states and
    // is cleared on every state change, so each ISSUE/RELEASE/GAP visit
    // starts counting from zero.
    always_comb begin
        state_next = state;
        step_next  = step;
        cnt_next   = cnt;

        unique case (state)
            S_IDLE: begin
                if (start || (AUTO_START && first_cycle)) begin
                    state_next = S_ISSUE;
                    step_next  = 4'd0;
                end
            end
            S_ISSUE: begin
                cnt_next = cnt + 1'b1;
                if (bus.done) begin
                    state_next = S_RELEASE;
                end else if (cnt == TIMEOUT_LAST) begin
                    state_next = S_ERROR;
                end
            end
            S_RELEASE: begin
                // A done that never falls (including one already high on
                // entry to ISSUE) ends up here and times out.
                cnt_next = cnt + 1'b1;
                if (!bus.done) begin
                    state_next = S_GAP;
                end else if (cnt == TIMEOUT_LAST) begin
                    state_next = S_ERROR;
                end
            end
            S_GAP: begin
                cnt_next = cnt + 1'b1;
                if (cnt == GAP_LAST) begin
                    if (step == LAST_STEP) begin
                        state_next = S_DONE;
                    end else begin
                        state_next = S_ISSUE;
                        step_next  = step + 4'd1;
                    end
                end
            end
            S_DONE, S_ERROR: begin
                if (start) begin
                    state_next = S_ISSUE;
                    step_next  = 4'd0;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase

        if (state_next != state) begin
            cnt_next = '0;
        end
    end

    // State and registered outputs. Outputs are derived from the next state
    // so they line up with the state they describe; the table entry is
    // latched only on entry to ISSUE so it stays stable through RELEASE.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state           <= S_IDLE;
            cnt             <= '0;
            step            <= 4'd0;
            first_cycle     <= 1'b1;
            bus.write       <= 1'b0;
            bus.config_reg  <= 8'h1E;
            bus.config_data <= 8'h00;
            busy            <= 1'b0;
            config_done     <= 1'b0;
            error           <= 1'b0;
        end else begin
            state       <= state_next;
            cnt         <= cnt_next;
            step        <= step_next;
            first_cycle <= 1'b0;
            bus.write   <= (state_next == S_ISSUE);
            if ((state_next == S_ISSUE) && (state != S_ISSUE)) begin
                {bus.config_reg, bus.config_data} <= table_entry(step_next);
            end
            busy        <= (state_next == S_ISSUE) || (state_next == S_RELEASE) ||
                           (state_next == S_GAP);
            config_done <= (state_next == S_DONE);
            error       <= (state_next == S_ERROR);
        end
    end

endmodule

// File: tb/tb_codec_init_seq.sv
// ---------------------------------------------------------------------------
// tb_codec_init_seq
//   Directed bench for codec_init_seq. Two instances share the clock:
//     dut_a  AUTO_START=1, GAP_CYCLES=4, TIMEOUT_CYCLES=100, with an
//            i2c_write model whose behaviour is selectable per test
//     dut_b  AUTO_START=0, same timing, with a well-behaved model
//   The i2c_write models assert done 20 cycles after write rises and drop it
//   2 cycles after write falls.
// ---------------------------------------------------------------------------
module tb_codec_init_seq;

    logic sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    logic       rst_a;
    logic       rst_b;
    logic       start_a;
    logic       start_b;
    logic       busy_a, config_done_a, error_a;
    logic       busy_b, config_done_b, error_b;
    logic [3:0] step_a;
    logic [3:0] step_b;

    codec_init_seq_if bus_a ();
    codec_init_seq_if bus_b ();

    codec_init_seq #(
        .NUM_REGS       (8),
        .GAP_CYCLES     (4),
        .TIMEOUT_CYCLES (100),
        .AUTO_START     (1'b1)
    ) dut_a (
        .sys_clk     (sys_clk),
        .rst         (rst_a),
        .start       (start_a),
        .bus         (bus_a),
        .busy        (busy_a),
        .config_done (config_done_a),
        .error       (error_a),
        .step        (step_a)
    );

    codec_init_seq #(
        .NUM_REGS       (8),
        .GAP_CYCLES     (4),
        .TIMEOUT_CYCLES (100),
        .AUTO_START     (1'b0)
    ) dut_b (
        .sys_clk     (sys_clk),
        .rst         (rst_b),
        .start       (start_b),
        .bus         (bus_b),
        .busy        (busy_b),
        .config_done (config_done_b),
        .error       (error_b),
        .step        (step_b)
    );

    int tests;
    int failures;
    int n_cycles;

    // Expected {config_reg, config_data} for each table entry.
    logic [15:0] exp_seq [8] = '{16'h1E00, 16'h0C00, 16'h0579, 16'h0812,
                                 16'h0A00, 16'h0E0A, 16'h1000, 16'h1201};

    // ---------------- i2c_write models (update on the falling edge) -------
    // mode_a: 0 normal, 1 never assert done, 2 hold done forever at step 3
    int   mode_a;
    int   cnt_a;
    int   cnt_b;
    logic done_a;
    logic done_b;

    always @(negedge sys_clk) begin
        if (rst_a) begin
            cnt_a  = 0;
            done_a = 1'b0;
        end else if (bus_a.write) begin
            if (!done_a && mode_a != 1) begin
                cnt_a++;
                if (cnt_a == 20) begin
                    done_a = 1'b1;
                    cnt_a  = 0;
                end
            end
        end else if (done_a) begin
            if (!(mode_a == 2 && step_a == 4'd3)) begin
                cnt_a++;
                if (cnt_a == 2) begin
                    done_a = 1'b0;
                    cnt_a  = 0;
                end
            end
        end else begin
            cnt_a = 0;
        end
        bus_a.done = done_a;
    end

    always @(negedge sys_clk) begin
        if (rst_b) begin
            cnt_b  = 0;
            done_b = 1'b0;
        end else if (bus_b.write) begin
            if (!done_b) begin
                cnt_b++;
                if (cnt_b == 20) begin
                    done_b = 1'b1;
                    cnt_b  = 0;
                end
            end
        end else if (done_b) begin
            cnt_b++;
            if (cnt_b == 2) begin
                done_b = 1'b0;
                cnt_b  = 0;
            end
        end else begin
            cnt_b = 0;
        end
        bus_b.done = done_b;
    end

    // ---------------- transfer logs (one entry per write rising edge) -----
    logic [15:0] log_a [$];
    logic [15:0] log_b [$];
    logic        prev_write_a = 1'b0;
    logic        prev_write_b = 1'b0;

    always @(negedge sys_clk) begin
        if (bus_a.write === 1'b1 && prev_write_a !== 1'b1) begin
            log_a.push_back({bus_a.config_reg, bus_a.config_data});
        end
        if (bus_b.write === 1'b1 && prev_write_b !== 1'b1) begin
            log_b.push_back({bus_b.config_reg, bus_b.config_data});
        end
        prev_write_a = bus_a.write;
        prev_write_b = bus_b.write;
    end

    // ---------------- helpers --------------------------------------------
    task automatic tick();
        @(negedge sys_clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        tests++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input bit to_b);
        if (to_b) start_b = 1'b1;
        else      start_a = 1'b1;
        tick();
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    task automatic checkLog(input string tag, input bit use_b);
        int          sz;
        logic [15:0] entry;
        sz = use_b ? log_b.size() : log_a.size();
        checkOutput({tag, "_count"}, 32'(sz), 32'd8);
        for (int i = 0; i < 8; i++) begin
            if (i < sz) entry = use_b ? log_b[i] : log_a[i];
            else        entry = 16'hFFFF;
            checkOutput($sformatf("%s_entry%0d", tag, i), {16'h0, entry}, {16'h0, exp_seq[i]});
        end
    endtask

    task automatic waitDoneA(input string tag);
        for (int i = 0; i < 2000 && !config_done_a; i++) tick();
        checkOutput(tag, config_done_a, 1'b1);
    endtask

    // ---------------- directed sequence ----------------------------------
    initial begin
        tests    = 0;
        failures = 0;
        n_cycles = 0;
        mode_a   = 0;
        rst_a    = 1'b1;
        rst_b    = 1'b1;
        start_a  = 1'b0;
        start_b  = 1'b0;

        repeat (3) tick();
        checkOutput("reset_write",       bus_a.write,       1'b0);
        checkOutput("reset_busy",        busy_a,            1'b0);
        checkOutput("reset_config_done", config_done_a,     1'b0);
        checkOutput("reset_error",       error_a,           1'b0);
        checkOutput("reset_step",        step_a,            4'd0);
        checkOutput("reset_config_reg",  bus_a.config_reg,  8'h1E);
        checkOutput("reset_config_data", bus_a.config_data, 8'h00);

        // Auto-start: write rises on the first edge after reset release.
        log_a.delete();
        log_b.delete();
        rst_a = 1'b0;
        rst_b = 1'b0;
        tick();
        checkOutput("auto_start_write", bus_a.write,      1'b1);
        checkOutput("auto_start_busy",  busy_a,           1'b1);
        checkOutput("auto_start_step",  step_a,           4'd0);
        checkOutput("auto_start_reg",   bus_a.config_reg, 8'h1E);

        // write stays high until done is sampled, then falls one edge later.
        for (int i = 0; i < 50 && !bus_a.done; i++) tick();
        checkOutput("done_seen",         bus_a.done,  1'b1);
        checkOutput("write_before_edge", bus_a.write, 1'b1);
        tick();
        checkOutput("write_fall_latency", bus_a.write, 1'b0);
        checkOutput("release_busy",       busy_a,      1'b1);
        checkOutput("release_reg_stable", bus_a.config_reg, 8'h1E);

        waitDoneA("seq1_complete");
        checkOutput("seq1_step",  step_a,      4'd7);
        checkOutput("seq1_busy",  busy_a,      1'b0);
        checkOutput("seq1_write", bus_a.write, 1'b0);
        checkOutput("seq1_error", error_a,     1'b0);
        checkLog("seq1", 1'b0);

        // Restart from DONE repeats the sequence identically.
        log_a.delete();
        applyStimulus(1'b0);
        checkOutput("restart_config_done", config_done_a, 1'b0);
        checkOutput("restart_write",       bus_a.write,   1'b1);
        checkOutput("restart_step",        step_a,        4'd0);
        waitDoneA("seq2_complete");
        checkLog("seq2", 1'b0);

        // Asynchronous reset while step 5 is being issued.
        applyStimulus(1'b0);
        for (int i = 0; i < 2000 && !(step_a == 4'd5 && bus_a.write); i++) tick();
        checkOutput("reached_step5_issue", {step_a, bus_a.write}, {4'd5, 1'b1});
        log_a.delete();
        rst_a = 1'b1;
        #1;
        checkOutput("async_reset_write", bus_a.write,      1'b0);
        checkOutput("async_reset_busy",  busy_a,           1'b0);
        checkOutput("async_reset_step",  step_a,           4'd0);
        checkOutput("async_reset_reg",   bus_a.config_reg, 8'h1E);
        tick();
        rst_a = 1'b0;
        waitDoneA("seq3_complete");
        checkLog("seq3", 1'b0);

        // ISSUE timeout: done never rises.
        mode_a = 1;
        applyStimulus(1'b0);
        checkOutput("to_issue_write", bus_a.write, 1'b1);
        n_cycles = 0;
        for (int i = 1; i <= 300; i++) begin
            tick();
            if (error_a) begin
                n_cycles = i;
                break;
            end
        end
        checkOutput("issue_timeout_cycles", n_cycles,    32'd100);
        checkOutput("issue_timeout_error",  error_a,     1'b1);
        checkOutput("issue_timeout_write",  bus_a.write, 1'b0);
        checkOutput("issue_timeout_step",   step_a,      4'd0);
        checkOutput("issue_timeout_busy",   busy_a,      1'b0);

        // RELEASE timeout: done stuck high at step 3.
        mode_a = 2;
        applyStimulus(1'b0);
        checkOutput("err_restart_error", error_a,     1'b0);
        checkOutput("err_restart_step",  step_a,      4'd0);
        checkOutput("err_restart_write", bus_a.write, 1'b1);
        for (int i = 0; i < 2000 && !error_a; i++) tick();
        checkOutput("release_timeout_error", error_a,       1'b1);
        checkOutput("release_timeout_step",  step_a,        4'd3);
        checkOutput("release_timeout_write", bus_a.write,   1'b0);
        checkOutput("release_timeout_cdone", config_done_a, 1'b0);

        // Let the model drop done, then recover with start.
        mode_a = 0;
        repeat (5) tick();
        log_a.delete();
        applyStimulus(1'b0);
        checkOutput("recover_error", error_a, 1'b0);
        checkOutput("recover_step",  step_a,  4'd0);
        waitDoneA("recover_complete");
        checkOutput("recover_final_step", step_a, 4'd7);
        checkLog("recover", 1'b0);

        // Manual-start instance has stayed idle all this time.
        checkOutput("manual_idle_busy",  busy_b,          1'b0);
        checkOutput("manual_idle_write", bus_b.write,     1'b0);
        checkOutput("manual_idle_step",  step_b,          4'd0);
        checkOutput("manual_idle_cdone", config_done_b,   1'b0);
        checkOutput("manual_idle_log",   32'(log_b.size()), 32'd0);

        applyStimulus(1'b1);
        checkOutput("manual_start_write", bus_b.write, 1'b1);

        // Find the end of step 2's RELEASE, then pulse start inside its GAP.
        for (int i = 0; i < 2000 &&
             !(step_b == 4'd2 && busy_b && !bus_b.write && !bus_b.done); i++) tick();
        checkOutput("manual_reached_gap2", {step_b, busy_b, bus_b.write},
                    {4'd2, 1'b1, 1'b0});
        tick();
        start_b = 1'b1;
        tick();
        tick();
        start_b = 1'b0;

        for (int i = 0; i < 2000 && !config_done_b; i++) tick();
        checkOutput("manual_complete", config_done_b, 1'b1);
        repeat (40) tick();
        checkOutput("manual_stays_done", config_done_b, 1'b1);
        checkOutput("manual_final_step", step_b,        4'd7);
        checkOutput("manual_error",      error_b,       1'b0);
        checkLog("manual", 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

    initial begin
        #500_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
